// File: rtl/risc_prog_loader.sv
// risc_prog_loader: serial program loader for a small RISC core.
// Streams a count byte followed by hi/lo byte pairs into instruction memory,
// holding the CPU in stall until the load finishes.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
//
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   start        - one-cycle load request (honoured in IDLE/DONE/ERR only)
//   byte_in      - serial program byte
//   byte_valid   - byte_in valid this cycle
//   byte_ready   - loader accepts a byte this cycle
//   imem_we      - one-cycle instruction-memory write strobe
//   imem_addr    - instruction-memory word address (held between writes)
//   imem_wdata   - instruction word (held between writes)
//   cpu_stall    - holds the processor while high
//   done / error - sticky load status
module risc_prog_loader #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_stall,
  output logic              done,
  output logic              error
);

  // Word counts run 1..2^ADDR_W, so they need one bit more than an address.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_DONE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_ERR   = 3'd5,
    S_CHK   = 3'd6
`else
    S_ERR   = 3'd5
`endif
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  n_q, n_next;
  logic [CNT_W-1:0]  idx_q, idx_next;
  logic [7:0]        hi_q, hi_next;
  logic [CNT_W-1:0]  cnt_raw;
  logic              xfer;

  logic              ready_d, we_d, stall_d, done_d, error_d;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       wdata_d;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_next;
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  assign xfer    = byte_valid & byte_ready;
  assign cnt_raw = byte_in[ADDR_W:0];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      hi_q       <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_stall  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state      <= state_next;
      n_q        <= n_next;
      idx_q      <= idx_next;
      hi_q       <= hi_next;
      byte_ready <= ready_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      cpu_stall  <= stall_d;
      done       <= done_d;
      error      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_next;
`endif
    end
  end

  // Next-state and registered-output inputs.
  always_comb begin
    state_next = state;
    n_next     = n_q;
    idx_next   = idx_q;
    hi_next    = hi_q;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
`ifdef LOADER_CHECKSUM_EN
    csum_next  = csum_q;
`endif

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_next = S_COUNT;
          idx_next   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_next  = '0;
`endif
        end
      end
      S_COUNT: begin
        if (xfer) begin
          // Zero and oversize counts both mean "fill the whole memory".
          n_next     = ((cnt_raw == '0) || (cnt_raw > DEPTH)) ? DEPTH : cnt_raw;
          idx_next   = '0;
          state_next = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_next    = byte_in;
          state_next = S_LO;
`ifdef LOADER_CHECKSUM_EN
          csum_next  = csum_q ^ byte_in;
`endif
        end
      end
      S_LO: begin
        if (xfer) begin
          we_d       = 1'b1;
          addr_d     = idx_q[ADDR_W-1:0];
          wdata_d    = {hi_q, byte_in};
          idx_next   = idx_q + CNT_W'(1);
          state_next = ((idx_q + CNT_W'(1)) < n_q) ? S_HI : S_END;
`ifdef LOADER_CHECKSUM_EN
          csum_next  = csum_q ^ byte_in;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_next = (byte_in == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase

    // Status outputs are decoded from the state being entered, so they
    // line up with the registered state.
    ready_d = (state_next == S_COUNT) || (state_next == S_HI) ||
              (state_next == S_LO)
`ifdef LOADER_CHECKSUM_EN
              || (state_next == S_CHK)
`endif
              ;
    stall_d = ready_d || (state_next == S_ERR);
    done_d  = (state_next == S_DONE);
    error_d = (state_next == S_ERR);
  end

endmodule

// File: tb/tb_risc_prog_loader.sv
// tb_risc_prog_loader: self-checking bench for risc_prog_loader.
// Directed and randomized loads are compared against a byte-stream model
// of the expected memory writes and final status.
module tb_risc_prog_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_stall;
  logic              done;
  logic              error;

  int n_assert = 0;
  int n_fail   = 0;

  int obs_addr[$];
  int obs_data[$];

  risc_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen, one entry per high cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      obs_addr.push_back(int'(imem_addr));
      obs_data.push_back(int'(imem_wdata));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feed bytes; mode 0 = valid held, 1 = toggled, 2 = random gaps.
  // start_at >= 0 raises start together with the first attempt at that byte.
  task automatic send_stream(input logic [7:0] bs[$], input int mode, input int start_at,
                             output bit ok);
    int  i = 0;
    int  cyc = 0;
    bit  started = 1'b0;
    logic v, rdy;
    while (i < bs.size() && cyc < 2000) begin
      @(negedge clk);
      byte_in = bs[i];
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      byte_valid = v;
      if (i == start_at && !started) begin
        start   = 1'b1;
        started = 1'b1;
      end else begin
        start = 1'b0;
      end
      rdy = byte_ready;
      @(posedge clk);
      if (v && rdy) i++;
      cyc++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    ok = (i == bs.size());
  endtask

  // Run one load and compare writes and final status against the model.
  task automatic do_load(input string tag, input logic [7:0] count_b, input logic [15:0] words[$],
                         input int mode, input int start_at, input bit bad_csum);
    logic [7:0] bs[$];
    logic [7:0] x;
    int  n, cyc;
    bit  ok, exp_done;
    n = int'(count_b) & (2 * DEPTH - 1);
    if (n == 0 || n > DEPTH) n = DEPTH;
    bs.push_back(count_b);
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      bs.push_back(words[i][15:8]);
      bs.push_back(words[i][7:0]);
      x = x ^ words[i][15:8] ^ words[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    bs.push_back(bad_csum ? (x ^ 8'h01) : x);
    exp_done = !bad_csum;
`else
    exp_done = 1'b1;
`endif
    obs_addr.delete();
    obs_data.delete();
    pulse_start();
    send_stream(bs, mode, start_at, ok);
    check({tag, " stream"}, 32'(ok), 32'd1);
    cyc = 0;
    while (!(done === 1'b1 || error === 1'b1) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check({tag, " nwrites"}, 32'(obs_addr.size()), 32'(n));
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      check({tag, " addr"}, 32'(obs_addr[i]), 32'(i));
      check({tag, " data"}, 32'(obs_data[i]), 32'(words[i]));
    end
    check({tag, " done"},  32'(done),  32'(exp_done));
    check({tag, " error"}, 32'(error), 32'(!exp_done));
    check({tag, " stall"}, 32'(cpu_stall), 32'(!exp_done));
    check({tag, " ready"}, 32'(byte_ready), 32'd0);
    check({tag, " we"},    32'(imem_we), 32'd0);
    check({tag, " hold addr"},  32'(imem_addr),  32'(n - 1));
    check({tag, " hold wdata"}, 32'(imem_wdata), 32'(words[n-1]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"}, 32'(byte_ready), 32'd0);
    check({tag, " we"},    32'(imem_we),    32'd0);
    check({tag, " addr"},  32'(imem_addr),  32'd0);
    check({tag, " wdata"}, 32'(imem_wdata), 32'd0);
    check({tag, " stall"}, 32'(cpu_stall),  32'd0);
    check({tag, " done"},  32'(done),       32'd0);
    check({tag, " error"}, 32'(error),      32'd0);
  endtask

  initial begin
    logic [15:0] w[$];
    logic [7:0]  bs[$];
    logic [7:0]  cb;
    bit ok;

    rst = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    // Basic two-word load.
    w = '{16'h1234, 16'hABCD};
    do_load("two_word", 8'h02, w, 0, -1, 1'b0);

    // Zero count fills the whole memory.
    w.delete();
    for (int i = 0; i < DEPTH; i++) w.push_back(16'($urandom()));
    do_load("count0", 8'h00, w, 0, -1, 1'b0);

    // Oversize count saturates to full depth.
    w.delete();
    for (int i = 0; i < DEPTH; i++) w.push_back(16'($urandom()));
    do_load("count_big", 8'h1F, w, 2, -1, 1'b0);

    // Toggled valid on a single-word load.
    w = '{16'h5A5A};
    do_load("toggle", 8'h01, w, 1, -1, 1'b0);

    // start during HI (coinciding with the HI byte) is ignored.
    w = '{16'hC0DE, 16'hBEEF, 16'h0001};
    do_load("start_in_hi", 8'h03, w, 0, 1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    w = '{16'h1234, 16'hABCD};
    do_load("csum_good", 8'h02, w, 0, -1, 1'b0);
    do_load("csum_bad",  8'h02, w, 0, -1, 1'b1);
    w = '{16'h0F0F};
    do_load("csum_restart", 8'h01, w, 2, -1, 1'b0);
`endif

    // Reset mid-load after the HI byte of the second word.
    obs_addr.delete();
    obs_data.delete();
    pulse_start();
    bs = '{8'h02, 8'h12, 8'h34, 8'hAB};
    send_stream(bs, 0, -1, ok);
    check("midrst stream", 32'(ok), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst nwrites", 32'(obs_addr.size()), 32'd1);
    check("midrst we", 32'(imem_we), 32'd0);
    if (obs_addr.size() > 0) begin
      check("midrst addr0", 32'(obs_addr[0]), 32'd0);
      check("midrst data0", 32'(obs_data[0]), 32'h1234);
    end
    w = '{16'h1234, 16'hABCD};
    do_load("after_rst", 8'h02, w, 0, -1, 1'b0);

    // Randomized loads.
    for (int k = 0; k < 8; k++) begin
      cb = 8'($urandom());
      w.delete();
      for (int i = 0; i < DEPTH; i++) w.push_back(16'($urandom()));
`ifdef LOADER_CHECKSUM_EN
      do_load("random", cb, w, int'($urandom_range(0, 2)), -1, 1'($urandom_range(0, 1)));
`else
      do_load("random", cb, w, int'($urandom_range(0, 2)), -1, 1'b0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
